// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its output stage.
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP            = 32'd4;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_reg.sv
// Valid/ready output register holding a fetched instruction and the PC it came from.
module fetch_stage_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_ready,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // NOTE: the data registers are reset too, because the cleared instruction and
  // PC are visible on the outputs straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load && !i_flush) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory and
// hands words to decode through a valid/ready stage, with redirect and halt support.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted,
  output logic               misalign_err,
  output logic [31:0]        fetch_count
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_misalign_err;
  logic [31:0]       r_fetch_count;

  logic w_load;
  logic w_accept;
  logic w_is_halt;

  assign w_accept  = if_valid && if_ready;
  assign w_is_halt = (imem_data == HALT_INSTR);

  // A redirect wins over a load: the word at the old PC is on the wrong path.
  assign w_load = (r_state == ST_RUN) && (!if_valid || if_ready) && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
    end else if (redirect_valid) begin
      r_pc    <= align_word(redirect_pc);
      r_state <= ST_RUN;
    end else if (w_load) begin
      if (w_is_halt) begin
        r_state <= ST_HALTED;
      end else begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
    end else if (redirect_valid && is_misaligned(redirect_pc)) begin
      r_misalign_err <= 1'b1;
    end
  end

  // Counts every handshake, including one that lands in a redirect cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_accept) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  fetch_stage_reg u_stage (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (redirect_valid),
    .i_ready (if_ready),
    .i_instr (imem_data),
    .i_pc    (r_pc),
    .o_valid (if_valid),
    .o_instr (if_instr),
    .o_pc    (if_pc)
  );

  assign imem_addr    = r_pc;
  assign halted       = (r_state == ST_HALTED);
  assign misalign_err = r_misalign_err;
  assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle model plus directed literal checks.
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT    = 32'hFFFF_FFFF;
  localparam logic [31:0] NO_HALT = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] halt_addr = NO_HALT;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Memory contents: a recognisable word per address, halt word at halt_addr.
  function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic [31:0] h);
    return (addr == h) ? HALT : (32'hC0DE_0000 ^ addr);
  endfunction

  assign imem_data = mem_word(imem_addr, halt_addr);

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  // Behavioural model: next fetch address, one output slot, halt flag, accepted-PC log.
  logic [31:0] m_pc, m_instr, m_ipc, m_count;
  logic        m_valid, m_halted, m_mis;
  logic [31:0] m_acc[$];
  logic [31:0] m_word;

  assign m_word = mem_word(m_pc, halt_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_valid <= 1'b0; m_instr <= '0; m_ipc <= '0;
      m_halted <= 1'b0; m_mis <= 1'b0; m_count <= '0;
      m_acc.delete();
    end else begin
      if (m_valid && if_ready) begin
        m_count <= m_count + 1;
        m_acc.push_back(m_ipc);
      end
      if (redirect_valid) begin
        m_pc     <= redirect_pc & ~32'h3;
        m_valid  <= 1'b0;
        m_halted <= 1'b0;
        if (redirect_pc % 4 != 0) m_mis <= 1'b1;
      end else if (!m_halted && (!m_valid || if_ready)) begin
        m_instr <= m_word;
        m_ipc   <= m_pc;
        m_valid <= 1'b1;
        if (m_word == HALT) m_halted <= 1'b1;
        else                m_pc <= m_pc + 4;
      end else if (m_valid && if_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("imem_addr", imem_addr, m_pc);
      check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      if (m_valid) begin
        check("if_instr", if_instr, m_instr);
        check("if_pc", if_pc, m_ipc);
      end
      check("halted", {31'b0, halted}, {31'b0, m_halted});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
      check("fetch_count", fetch_count, m_count);
    end
  end

  // Drive inputs for one edge; returns just after the following falling edge.
  task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk); #1;
    check("rst if_valid", {31'b0, if_valid}, 32'd0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst if_pc", if_pc, 32'h0);
    check("rst if_instr", if_instr, 32'h0);
    check("rst fetch_count", fetch_count, 32'd0);
    rst = 1'b0;

    // Sequential fetch, one per cycle.
    tick(1, 0, 0); check("seq pc0", if_pc, 32'h0); check("seq valid0", {31'b0, if_valid}, 32'd1);
    check("seq instr0", if_instr, 32'hC0DE_0000);
    tick(1, 0, 0); check("seq pc4", if_pc, 32'h4);
    tick(1, 0, 0); check("seq pc8", if_pc, 32'h8);
    tick(1, 0, 0); check("seq pc12", if_pc, 32'hC);
    tick(1, 0, 0); check("seq count4", fetch_count, 32'd4);
    check("seq log", m_acc[3], 32'hC);

    // Back-pressure at if_pc=8.
    tick(1, 1, 32'h0); check("rd0 valid", {31'b0, if_valid}, 32'd0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0); check("bp pc8", if_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      check("bp hold pc", if_pc, 32'h8);
      check("bp hold addr", imem_addr, 32'hC);
      check("bp hold count", fetch_count, 32'd7);
    end
    tick(1, 0, 0); check("bp release pc", if_pc, 32'hC);

    // Redirect while stalled: pending word dropped.
    tick(0, 1, 32'h40); check("rd40 valid", {31'b0, if_valid}, 32'd0);
    check("rd40 addr", imem_addr, 32'h40);
    tick(1, 0, 0); check("rd40 pc", if_pc, 32'h40);
    check("rd40 dropped", m_acc[m_acc.size()-1], 32'h8);
    check("rd40 count", fetch_count, 32'd8);

    // Halt word at 0x10.
    halt_addr = 32'h10;
    tick(1, 1, 32'h8);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0); check("halt pc", if_pc, 32'h10); check("halt instr", if_instr, HALT);
    check("halted", {31'b0, halted}, 32'd1); check("halt addr", imem_addr, 32'h10);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0); check("halt idle", {31'b0, if_valid}, 32'd0);
    tick(1, 1, 32'h0); check("unhalt", {31'b0, halted}, 32'd0);
    tick(1, 0, 0); check("resume pc", if_pc, 32'h0);
    halt_addr = NO_HALT;

    // Misaligned redirect and address wrap.
    tick(1, 1, 32'h23); check("mis err", {31'b0, misalign_err}, 32'd1);
    tick(1, 0, 0); check("mis pc", if_pc, 32'h20);
    tick(1, 1, 32'hFFFF_FFFC);
    tick(1, 0, 0); check("wrap top", if_pc, 32'hFFFF_FFFC); check("wrap addr", imem_addr, 32'h0);
    tick(1, 0, 0); check("wrap zero", if_pc, 32'h0);
    check("mis sticky", {31'b0, misalign_err}, 32'd1);

    // Asynchronous reset mid-stream.
    #2 rst = 1'b1;
    #1;
    check("arst valid", {31'b0, if_valid}, 32'd0);
    check("arst addr", imem_addr, 32'h0);
    check("arst if_pc", if_pc, 32'h0);
    check("arst mis", {31'b0, misalign_err}, 32'd0);
    check("arst count", fetch_count, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    tick(1, 0, 0); check("post rst pc", if_pc, 32'h0);
    check("post rst valid", {31'b0, if_valid}, 32'd1);
    tick(1, 0, 0); check("post rst pc4", if_pc, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
